load_store_unit: RTL
====================

# load_store_unit

Memory-stage initiator that turns a RISC-V load/store (funct3, byte address, store data) into word-aligned accesses on a byte-enabled, synchronous-read data RAM port. It builds byte enables and lane-shifted write data, extracts and sign/zero-extends load data, and splits misaligned accesses into two word accesses. While an access is in flight it stalls the pipeline.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, word width; only 32 is supported
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  MEM stage holds a load/store; request fields are held stable while stall=1
- req_we  in  1  1=store, 0=load
- funct3  in  3  RV32I load/store funct3
- addr  in  ADDR_WIDTH  byte address
- wdata  in  DATA_WIDTH  store data, LSB-justified
- stall  out  1  combinational: req_valid & ~done
- done  out  1  one-cycle completion pulse
- rdata  out  DATA_WIDTH  load result; valid only while done=1 for a load, otherwise 0
- misalign_exc  out  1  asserted with done when a misaligned access is rejected (macro off only)
- mem_req  out  1  access strobe
- mem_wr_en  out  1  write strobe; RAM writes at the rising edge while mem_req & mem_wr_en
- mem_addr  out  ADDR_WIDTH  word address, bits [1:0]=0
- mem_be  out  4  byte enables, bit i = byte lane i
- mem_wdata  out  DATA_WIDTH  lane-aligned write data
- mem_rdata  in  DATA_WIDTH  read word, valid the cycle after a read mem_req

## Operation
- States: IDLE, REQ0, REQ1, RESP.
- IDLE: if req_valid, latch req_we/funct3/addr/wdata.
  - Access legal → REQ0.
  - Illegal funct3 (load 011/110/111, store not 000/001/010) → RESP with no memory access.
- REQ0: mem_req=1, mem_addr={addr[31:2],2'b00}, mem_be=be[3:0], mem_wdata=sh[31:0]. Next state is REQ1 if split, else RESP.
- REQ1: mem_req=1, mem_addr=first word +4 (modulo 2^ADDR_WIDTH), mem_be=be[7:4], mem_wdata=sh[63:32]. Latches mem_rdata (word0) into a buffer. Next state is RESP.
- RESP: done=1. For a load, rdata is formed from {mem_rdata, buffer} (split) or {32'b0, mem_rdata} (unsplit). Next state is IDLE.
- Size: byte=1, half=2, word=4 bytes. mask = (1<<size)-1.
- be = mask << addr[1:0], 8 bits wide.
- sh = zero-extended sized wdata << 8*addr[1:0], 64 bits wide.
- Split: addr[1:0]+size > 4. This covers a half at offset 3 and a word at offset ≠0.
- Load data is the 64-bit assembly >> 8*addr[1:0], truncated to size.
  - lb/lh: sign-extend.
  - lbu/lhu: zero-extend.
  - lw: as-is.
- mem_* outputs are all 0 in IDLE and RESP. mem_wr_en = req_we in REQ0/REQ1.
- Stores never read memory; store rdata=0.

## Timing
- Reset: state IDLE, buffer 0. done, stall (given req_valid=0), rdata, misalign_exc and all mem_* are 0.
- Request seen in IDLE at cycle t:
  - Aligned: REQ0 at t+1, done at t+2.
  - Split: REQ1 at t+2, done at t+3.
  - Illegal or rejected: done at t+1.
- Back-to-back: the cycle after done is IDLE. A new req_valid there is accepted. Minimum spacing between accepted requests is 2 cycles.
- Reset mid-split-store: the first word may already be written; there is no rollback. The FSM returns to IDLE immediately.
- req_valid dropping while not in IDLE is ignored. The latched request completes.

## Configuration
- LSU_MISALIGNED_EN defined: split accesses are performed as above. misalign_exc is tied 0.
- Not defined: a split condition in IDLE goes directly to RESP with no memory access. done=1, misalign_exc=1, rdata=0. REQ1 is unreachable and may be removed.

## Structure
- Package lsu_pkg: state encoding, funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW), size/mask helper constants.
- Sub-module load_align: combinational; 64-bit assembly, offset, funct3 → rdata. Reused by any future cache path.

## Test plan
- sw 0xDEADBEEF @0x10 → one REQ0 cycle: mem_addr 0x10, be 1111, wdata 0xDEADBEEF; done at t+2.
- sb 0x000000A5 @0x23 → mem_addr 0x20, be 1000, mem_wdata 0xA5000000.
- lb @0x21 with mem_rdata 0x12348056 → rdata 0xFFFFFF80. lbu at the same address → 0x00000080.
- lw @0x0E, words 0x0C=0x44332211 and 0x10=0x88776655:
  - Macro on: two accesses (0x0C, 0x10); rdata 0x66554433 at t+3.
  - Macro off: misalign_exc=1 and done at t+1; no mem_req.
- sh 0xBEEF @0xFFFFFFFF (macro on) → word 0xFFFFFFFC with be 1000, data 0xEF000000. Then word 0x00000000 with be 0001, data 0x000000BE.
- Reset asserted in REQ1 of a split store → next cycle IDLE, all outputs 0; a following aligned lw completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared state encoding, funct3 constants and size helpers for the load/store unit
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ0 = 2'd1,
        REQ1 = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;

    // Access size in bytes, taken from funct3[1:0].
    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (sz)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [3:0] size_mask(input logic [1:0] sz);
        case (sz)
            SZ_B:    return 4'b0001;
            SZ_H:    return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic is_legal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 == SB) || (f3 == SH) || (f3 == SW);
        else
            return (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
    endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - extracts and sign/zero-extends load data from a 64-bit two-word assembly
module load_align
    import lsu_pkg::*;
(
    input  logic [63:0] data,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata
);

    logic [31:0] win;

    always_comb begin
        win = data[{offset, 3'b000} +: 32];
        case (funct3)
            LB:      rdata = {{24{win[7]}}, win[7:0]};
            LH:      rdata = {{16{win[15]}}, win[15:0]};
            LW:      rdata = win;
            LBU:     rdata = {24'b0, win[7:0]};
            LHU:     rdata = {16'b0, win[15:0]};
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32 load/store initiator on a byte-enabled synchronous RAM port
// Split (misaligned) accesses are performed only when LSU_MISALIGNED_EN is defined; otherwise they raise misalign_exc.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  stall,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  misalign_exc,
    output logic                  mem_req,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    lsu_state_e state, state_next;

    logic                  r_we;
    logic [2:0]            r_funct3;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_noacc;
    logic [DATA_WIDTH-1:0] buffer;

    logic                    req_legal;
    logic                    req_noacc;
    logic [1:0]              r_off;
    logic [3:0]              r_mask;
    logic                    r_split;
    logic [7:0]              be8;
    logic [DATA_WIDTH-1:0]   w_sized;
    logic [2*DATA_WIDTH-1:0] sh;
    logic [2*DATA_WIDTH-1:0] assembly;
    logic [DATA_WIDTH-1:0]   aligned;
    logic [ADDR_WIDTH-3:0]   word_idx_next;

`ifndef LSU_MISALIGNED_EN
    logic r_exc;
    logic req_split;
`endif

    assign req_legal = is_legal(req_we, funct3);
`ifdef LSU_MISALIGNED_EN
    assign req_noacc = ~req_legal;
`else
    assign req_split = ({1'b0, addr[1:0]} + size_bytes(funct3[1:0])) > 3'd4;
    assign req_noacc = ~req_legal | req_split;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            r_we     <= 1'b0;
            r_funct3 <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_noacc  <= 1'b0;
            buffer   <= '0;
`ifndef LSU_MISALIGNED_EN
            r_exc    <= 1'b0;
`endif
        end else begin
            state <= state_next;
            if (state == IDLE && req_valid) begin
                r_we     <= req_we;
                r_funct3 <= funct3;
                r_addr   <= addr;
                r_wdata  <= wdata;
                r_noacc  <= req_noacc;
`ifndef LSU_MISALIGNED_EN
                r_exc    <= req_legal & req_split;
`endif
            end
            // Word0 read data arrives during REQ1; hold it for the RESP assembly.
            if (state == REQ1)
                buffer <= mem_rdata;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (req_valid) state_next = req_noacc ? RESP : REQ0;
`ifdef LSU_MISALIGNED_EN
            REQ0: state_next = r_split ? REQ1 : RESP;
`else
            REQ0: state_next = RESP;
`endif
            REQ1: state_next = RESP;
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign r_off         = r_addr[1:0];
    assign r_mask        = size_mask(r_funct3[1:0]);
    assign r_split       = ({1'b0, r_off} + size_bytes(r_funct3[1:0])) > 3'd4;
    assign be8           = {4'b0, r_mask} << r_off;
    assign w_sized       = r_wdata & {{8{r_mask[3]}}, {8{r_mask[2]}}, {8{r_mask[1]}}, {8{r_mask[0]}}};
    assign sh            = {{DATA_WIDTH{1'b0}}, w_sized} << {r_off, 3'b000};
    assign word_idx_next = r_addr[ADDR_WIDTH-1:2] + {{(ADDR_WIDTH-3){1'b0}}, 1'b1};

    always_comb begin
        mem_req   = 1'b0;
        mem_wr_en = 1'b0;
        mem_addr  = '0;
        mem_be    = '0;
        mem_wdata = '0;
        done      = 1'b0;
        case (state)
            REQ0: begin
                mem_req   = 1'b1;
                mem_wr_en = r_we;
                mem_addr  = {r_addr[ADDR_WIDTH-1:2], 2'b00};
                mem_be    = be8[3:0];
                mem_wdata = sh[DATA_WIDTH-1:0];
            end
            REQ1: begin
                mem_req   = 1'b1;
                mem_wr_en = r_we;
                mem_addr  = {word_idx_next, 2'b00};
                mem_be    = be8[7:4];
                mem_wdata = sh[2*DATA_WIDTH-1:DATA_WIDTH];
            end
            RESP: done = 1'b1;
            default: ;
        endcase
    end

    assign assembly = r_split ? {mem_rdata, buffer} : {{DATA_WIDTH{1'b0}}, mem_rdata};

    load_align u_load_align (
        .data   (assembly),
        .offset (r_off),
        .funct3 (r_funct3),
        .rdata  (aligned)
    );

    assign stall = req_valid & ~done;
    assign rdata = (done && !r_we && !r_noacc) ? aligned : '0;

`ifdef LSU_MISALIGNED_EN
    assign misalign_exc = 1'b0;
`else
    assign misalign_exc = done & r_exc;
`endif

endmodule
